// File: rtl/uart_stream_core_if.sv
// Host-side stream interface of uart_stream_core.
// Valid/ready: a word moves on a rising clk edge where valid and ready are
// both high. The source holds data stable while valid is high and ready is
// low. The sink may raise or drop ready at any time. rx_data is the RX FIFO
// head (first-word-fall-through) and is meaningful only while rx_valid is high.
interface uart_stream_core_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_SIZE-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    // Host side: produces TX words and consumes RX words.
    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    // UART core side.
    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_stream_core.sv
// uart_stream_core: one UART channel with TX/RX engines, programmable
// oversampling tick (16 ticks per bit), TX/RX FIFOs, runtime parity and
// stop-bit configuration, sticky error flags and an RX->TX echo mode.

// Circular-buffer FIFO with first-word-fall-through read port.
module uart_stream_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [DW-1:0]    pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    // A push at full is dropped even if a pop happens in the same cycle.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module uart_stream_core #(
    parameter int DATA_SIZE  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] cfg_baud_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 cfg_echo,
    uart_stream_core_if.slave    host,
    input  logic                 rx,
    output logic                 tx,
    output logic                 tx_busy,
    output logic [LVL_W-1:0]     tx_level,
    output logic [LVL_W-1:0]     rx_level,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_overrun,
    input  logic                 err_clear,
    output logic [2:0]           dbg_tx_state,
    output logic [2:0]           dbg_rx_state
);
    localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Oversampling tick: one s_tick every cfg_baud_div+1 clocks.
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] tick_cnt;
    logic                 s_tick;

    assign s_tick = (tick_cnt == cfg_baud_div);

    // Free-running tick counter, cleared on each tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (s_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Live configuration decode (latched by each FSM when it leaves IDLE).
    // ------------------------------------------------------------------
    logic cfg_par_en;
    logic cfg_par_odd;

    assign cfg_par_en  = (cfg_parity == 2'b01) | (cfg_parity == 2'b10);
    assign cfg_par_odd = (cfg_parity == 2'b10);

    // ------------------------------------------------------------------
    // FIFOs and host / echo routing.
    // ------------------------------------------------------------------
    logic                 tx_fifo_push;
    logic [DATA_SIZE-1:0] tx_fifo_din;
    logic                 tx_fifo_pop;
    logic [DATA_SIZE-1:0] tx_head;
    logic                 tx_full;
    logic                 tx_empty;

    logic                 rx_fifo_push;
    logic                 rx_fifo_pop;
    logic [DATA_SIZE-1:0] rx_head;
    logic                 rx_full;
    logic                 rx_empty;

    logic                 echo_move;
    logic [DATA_SIZE-1:0] rx_shift;

    // Echo drains RX into TX one byte per cycle while TX has room.
    assign echo_move     = cfg_echo & ~rx_empty & ~tx_full;

    assign host.tx_ready = ~tx_full & ~reset & ~cfg_echo;
    assign host.rx_valid = ~rx_empty & ~cfg_echo;
    assign host.rx_data  = rx_head;

    assign tx_fifo_push  = cfg_echo ? echo_move : (host.tx_valid & host.tx_ready);
    assign tx_fifo_din   = cfg_echo ? rx_head : host.tx_data;
    assign rx_fifo_pop   = cfg_echo ? echo_move : (host.rx_valid & host.rx_ready);

    uart_stream_fifo #(
        .DW    (DATA_SIZE),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_fifo_push),
        .push_data (tx_fifo_din),
        .pop       (tx_fifo_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    uart_stream_fifo #(
        .DW    (DATA_SIZE),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_fifo_push),
        .push_data (rx_shift),
        .pop       (rx_fifo_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    // ------------------------------------------------------------------
    // TX engine.
    // ------------------------------------------------------------------
    tx_state_t            tx_state;
    logic [4:0]           tx_tcnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_SIZE-1:0] tx_shift;
    logic                 tx_par_bit;
    logic                 tx_par_en;
    logic                 tx_stop2;
    logic [4:0]           tx_stop_last;
    logic                 tx_load;

    assign tx_stop_last = tx_stop2 ? 5'd31 : 5'd15;
    // A new frame starts from IDLE, or directly at the end of STOP so that
    // back-to-back frames carry no extra idle time.
    assign tx_load = s_tick & ~tx_empty &
                     ((tx_state == TX_IDLE) |
                      ((tx_state == TX_STOP) & (tx_tcnt == tx_stop_last)));
    assign tx_fifo_pop  = tx_load;
    assign dbg_tx_state = tx_state;

    // TX frame sequencer with registered serial output and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_tcnt    <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par_bit <= 1'b0;
            tx_par_en  <= 1'b0;
            tx_stop2   <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
        end else if (tx_load) begin
            tx_shift   <= tx_head;
            tx_par_bit <= ^tx_head ^ cfg_par_odd;
            tx_par_en  <= cfg_par_en;
            tx_stop2   <= cfg_stop2;
            tx_tcnt    <= '0;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            tx_state   <= TX_START;
        end else if (s_tick) begin
            case (tx_state)
                TX_START: begin
                    if (tx_tcnt == 5'd15) begin
                        tx_tcnt  <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_tcnt == 5'd15) begin
                        tx_tcnt <= '0;
                        if (tx_bit == LAST_BIT) begin
                            if (tx_par_en) begin
                                tx       <= tx_par_bit;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + BIT_W'(1);
                            tx_shift <= tx_shift >> 1;
                            tx       <= tx_shift[1];
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                TX_PARITY: begin
                    if (tx_tcnt == 5'd15) begin
                        tx_tcnt  <= '0;
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_tcnt == tx_stop_last) begin
                        tx_tcnt  <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_tcnt <= tx_tcnt + 5'd1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX engine.
    // ------------------------------------------------------------------
    logic [1:0]       rx_sync;
    logic             rx_s;
    rx_state_t        rx_state;
    logic [3:0]       rx_tcnt;
    logic [BIT_W-1:0] rx_bit;
    logic             rx_par_en;
    logic             rx_par_odd;
    logic             rx_par_bad;
    logic             rx_push;
    logic             rx_frame_evt;
    logic             rx_par_evt;

    assign rx_s         = rx_sync[1];
    assign rx_fifo_push = rx_push;
    assign dbg_rx_state = rx_state;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    // RX frame sequencer: mid-bit sampling, end-of-frame event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_tcnt      <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_par_en    <= 1'b0;
            rx_par_odd   <= 1'b0;
            rx_par_bad   <= 1'b0;
            rx_push      <= 1'b0;
            rx_frame_evt <= 1'b0;
            rx_par_evt   <= 1'b0;
        end else begin
            rx_push      <= 1'b0;
            rx_frame_evt <= 1'b0;
            rx_par_evt   <= 1'b0;
            if (s_tick) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            rx_tcnt    <= '0;
                            rx_par_en  <= cfg_par_en;
                            rx_par_odd <= cfg_par_odd;
                            rx_par_bad <= 1'b0;
                            rx_state   <= RX_START;
                        end
                    end
                    RX_START: begin
                        // Half-bit re-check filters short low glitches.
                        if (rx_tcnt == 4'd7) begin
                            rx_tcnt  <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt  <= '0;
                            rx_shift <= {rx_s, rx_shift[DATA_SIZE-1:1]};
                            if (rx_bit == LAST_BIT) begin
                                rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit <= rx_bit + BIT_W'(1);
                            end
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt    <= '0;
                            rx_par_bad <= rx_s ^ (^rx_shift) ^ rx_par_odd;
                            rx_state   <= RX_STOP;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    RX_STOP: begin
                        // Only the first stop bit is examined.
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt  <= '0;
                            rx_state <= RX_IDLE;
                            if (!rx_s) begin
                                rx_frame_evt <= 1'b1;
                            end else begin
                                rx_push    <= 1'b1;
                                rx_par_evt <= rx_par_bad;
                            end
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    default: begin
                        rx_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_parity  <= rx_par_evt | (err_parity & ~err_clear);
            err_frame   <= rx_frame_evt | (err_frame & ~err_clear);
            err_overrun <= (rx_push & rx_full) | (err_overrun & ~err_clear);
        end
    end
endmodule

// File: tb/tb_uart_stream_core.sv
// Directed bench for uart_stream_core with FIFO_DEPTH=4 and 8-bit frames.
module tb_uart_stream_core;
    localparam int DS    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] cfg_baud_div = '0;
    logic [1:0]    cfg_parity = 2'b00;
    logic          cfg_stop2 = 1'b0;
    logic          cfg_echo = 1'b0;
    logic          rx = 1'b1;
    logic          tx;
    logic          tx_busy;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          err_parity;
    logic          err_frame;
    logic          err_overrun;
    logic          err_clear = 1'b0;
    logic [2:0]    dbg_tx_state;
    logic [2:0]    dbg_rx_state;

    uart_stream_core_if #(.DATA_SIZE(DS)) host_if ();

    uart_stream_core #(
        .DATA_SIZE  (DS),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DW),
        .LVL_W      (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_baud_div (cfg_baud_div),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .cfg_echo     (cfg_echo),
        .host         (host_if.slave),
        .rx           (rx),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_level     (tx_level),
        .rx_level     (rx_level),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_overrun  (err_overrun),
        .err_clear    (err_clear),
        .dbg_tx_state (dbg_tx_state),
        .dbg_rx_state (dbg_rx_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int bit_cycles = 16;
    int tx_extra = 0;
    logic [DS-1:0] rx_exp_q[$];
    logic [DS-1:0] tx_exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
        end
    endtask

    // TX line decoder (8N1): each decoded byte is compared with tx_exp_q.
    initial begin : tx_monitor
        logic [DS-1:0] b;
        logic [DS-1:0] e;
        bit            ab;
        int            bc;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                bc = bit_cycles;
                ab = 1'b0;
                b  = '0;
                mon_wait(bc / 2, ab);
                for (int k = 0; k < DS; k++) begin
                    mon_wait(bc, ab);
                    b[k] = tx;
                end
                mon_wait(bc, ab);
                if (!ab) begin
                    check("tx_stop_bit", tx, 1'b1);
                    if (tx_exp_q.size() == 0) begin
                        tx_extra++;
                    end else begin
                        e = tx_exp_q.pop_front();
                        check("tx_byte", b, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_tx(input string tag, input logic [DS-1:0] d, input bit expect_out);
        host_if.tx_data  = d;
        host_if.tx_valid = 1'b1;
        for (int i = 0; i < 200 && host_if.tx_ready !== 1'b1; i++) @(negedge clk);
        check(tag, host_if.tx_ready, 1'b1);
        if (expect_out) tx_exp_q.push_back(d);
        @(negedge clk);
        host_if.tx_valid = 1'b0;
    endtask

    // Drives one serial frame on rx; pmode 0 none, 1 even, 2 odd.
    task automatic send_rx(input logic [7:0] d, input int pmode, input bit flip,
                           input int nstop, input bit bad_stop);
        rx = 1'b0;
        wait_cycles(bit_cycles);
        for (int i = 0; i < DS; i++) begin
            rx = d[i];
            wait_cycles(bit_cycles);
        end
        if (pmode == 1 || pmode == 2) begin
            rx = (^d) ^ (pmode == 2) ^ flip;
            wait_cycles(bit_cycles);
        end
        if (bad_stop) begin
            rx = 1'b0;
            wait_cycles(bit_cycles * 3 / 4);
            rx = 1'b1;
            wait_cycles(bit_cycles / 4);
        end else begin
            rx = 1'b1;
            wait_cycles(bit_cycles);
        end
        for (int s = 1; s < nstop; s++) wait_cycles(bit_cycles);
        wait_cycles(bit_cycles);
    endtask

    task automatic read_rx(input string tag);
        logic [DS-1:0] e;
        for (int i = 0; i < 2000 && host_if.rx_valid !== 1'b1; i++) @(negedge clk);
        check({tag, "_valid"}, host_if.rx_valid, 1'b1);
        e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 'x;
        check(tag, host_if.rx_data, e);
        host_if.rx_ready = 1'b1;
        @(negedge clk);
        host_if.rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        bit ok_tx;
        bit ok_busy;
        bit bad_host;
        bit low_seen;
        logic [7:0] a5;
        logic exp_bit;

        host_if.tx_data  = '0;
        host_if.tx_valid = 1'b0;
        host_if.rx_ready = 1'b0;
        a5 = 8'hA5;

        // Reset state
        wait_cycles(4);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_rx_valid", host_if.rx_valid, 1'b0);
        check("rst_errs", {err_parity, err_frame, err_overrun}, 3'b000);
        check("rst_tx_ready", host_if.tx_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("tx_ready_after_rst", host_if.tx_ready, 1'b1);

        // 1: div=0, 8N1 frame of 0xA5, cycle-exact waveform and busy length
        bit_cycles = 16;
        push_tx("t1_push", a5, 1'b1);
        for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        check("t1_start_seen", tx, 1'b0);
        for (int b = 0; b < 10; b++) begin
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : a5[b-1];
            ok_tx   = 1'b1;
            ok_busy = 1'b1;
            for (int c = 0; c < 16; c++) begin
                if (tx !== exp_bit) ok_tx = 1'b0;
                if (tx_busy !== 1'b1) ok_busy = 1'b0;
                @(negedge clk);
            end
            check($sformatf("t1_bit%0d_level", b), ok_tx, 1'b1);
            check($sformatf("t1_bit%0d_busy", b), ok_busy, 1'b1);
        end
        check("t1_busy_end", tx_busy, 1'b0);
        check("t1_tx_idle", tx, 1'b1);
        check("t1_tx_level", tx_level, 0);
        wait_cycles(10);
        check("t1_tx_drained", tx_exp_q.size(), 0);

        // 2: div=3, even parity, 2 stop bits
        cfg_baud_div = 16'd3;
        bit_cycles   = 64;
        cfg_parity   = 2'b01;
        cfg_stop2    = 1'b1;
        rx_exp_q.push_back(8'h3C);
        send_rx(8'h3C, 1, 1'b0, 2, 1'b0);
        wait_cycles(8);
        check("t2_rx_level", rx_level, 1);
        check("t2_no_errs", {err_parity, err_frame, err_overrun}, 3'b000);
        read_rx("t2_byte");
        rx_exp_q.push_back(8'h3C);
        send_rx(8'h3C, 1, 1'b1, 2, 1'b0);
        wait_cycles(8);
        check("t2_err_parity", err_parity, 1'b1);
        check("t2_stored_level", rx_level, 1);
        read_rx("t2_bad_par_byte");
        pulse_clear();
        check("t2_err_cleared", err_parity, 1'b0);

        // 3: overrun with a 4-deep RX FIFO
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) rx_exp_q.push_back(8'(i));
            send_rx(8'(i), 0, 1'b0, 1, 1'b0);
        end
        wait_cycles(8);
        check("t3_rx_level", rx_level, DEPTH);
        check("t3_err_overrun", err_overrun, 1'b1);
        check("t3_err_frame", err_frame, 1'b0);
        for (int i = 0; i < DEPTH; i++) read_rx($sformatf("t3_byte%0d", i));
        check("t3_rx_empty", rx_level, 0);
        pulse_clear();
        check("t3_errs_cleared", {err_parity, err_frame, err_overrun}, 3'b000);

        // 4: bad stop bit, then a short low glitch
        send_rx(8'h55, 0, 1'b0, 1, 1'b1);
        wait_cycles(3 * bit_cycles);
        check("t4_err_frame", err_frame, 1'b1);
        check("t4_rx_level", rx_level, 0);
        check("t4_rx_valid", host_if.rx_valid, 1'b0);
        check("t4_rx_idle", dbg_rx_state, 3'd0);
        pulse_clear();
        rx = 1'b0;
        wait_cycles(4 * 4);
        rx = 1'b1;
        wait_cycles(20 * bit_cycles);
        check("t4_glitch_level", rx_level, 0);
        check("t4_glitch_errs", {err_parity, err_frame, err_overrun}, 3'b000);
        check("t4_glitch_idle", dbg_rx_state, 3'd0);

        // 5: echo mode; host strobes held active must be ignored
        cfg_echo         = 1'b1;
        host_if.tx_data  = 8'hEE;
        host_if.tx_valid = 1'b1;
        host_if.rx_ready = 1'b1;
        bad_host = 1'b0;
        foreach (a5[i]) begin end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'h11 * 8'(i + 1);
            tx_exp_q.push_back(d);
            send_rx(d, 0, 1'b0, 1, 1'b0);
            if (host_if.rx_valid !== 1'b0 || host_if.tx_ready !== 1'b0) bad_host = 1'b1;
        end
        for (int i = 0; i < 3000 && tx_exp_q.size() != 0; i++) begin
            if (host_if.rx_valid !== 1'b0 || host_if.tx_ready !== 1'b0) bad_host = 1'b1;
            @(negedge clk);
        end
        check("t5_echo_drained", tx_exp_q.size(), 0);
        check("t5_host_blocked", bad_host, 1'b0);
        wait_cycles(bit_cycles);
        check("t5_tx_level", tx_level, 0);
        check("t5_rx_level", rx_level, 0);
        host_if.tx_valid = 1'b0;
        host_if.rx_ready = 1'b0;
        cfg_echo         = 1'b0;
        wait_cycles(2);

        // 6: reset during data bit 3 with two bytes queued
        push_tx("t6_push0", 8'h5A, 1'b0);
        push_tx("t6_push1", 8'hC3, 1'b0);
        push_tx("t6_push2", 8'h96, 1'b0);
        for (int i = 0; i < 200 && tx !== 1'b0; i++) @(negedge clk);
        check("t6_start_seen", tx, 1'b0);
        wait_cycles(4 * bit_cycles);
        check("t6_queued", tx_level, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t6_tx", tx, 1'b1);
        check("t6_busy", tx_busy, 1'b0);
        check("t6_tx_level", tx_level, 0);
        check("t6_tx_state", dbg_tx_state, 3'd0);
        reset = 1'b0;
        low_seen = 1'b0;
        for (int i = 0; i < 24 * bit_cycles; i++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) low_seen = 1'b1;
            @(negedge clk);
        end
        check("t6_tx_quiet", low_seen, 1'b0);
        check("tx_extra_frames", tx_extra, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_stream_core.md
Name: uart_stream_core

Overview:
- Parametrised successor to the fixed-format UART echo block: one self-contained UART channel with TX and RX engines, a runtime-programmable oversampling tick, and TX/RX FIFOs.
- Adds host-side valid/ready streams, runtime parity, stop-bit and divisor configuration, sticky error flags, and a selectable echo mode that forwards received bytes back out on TX.
- Sits between the system bus adapter and the pads.

Parameters:
DATA_SIZE, 8, data bits per frame, legal range 5..8
FIFO_DEPTH, 16, entries per FIFO, power of two, minimum 2
DIV_WIDTH, 16, width of cfg_baud_div
LVL_W, $clog2(FIFO_DEPTH)+1, width of the level outputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
cfg_baud_div  in  DIV_WIDTH  s_tick period minus 1, in clk cycles
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  in  1  1 = two stop bits
cfg_echo  in  1  1 = echo mode: RX FIFO drains into TX FIFO
tx_data  in  DATA_SIZE  host write data
tx_valid  in  1  host write request
tx_ready  out  1  TX FIFO accepts data
rx_data  out  DATA_SIZE  RX FIFO head, first-word-fall-through
rx_valid  out  1  RX FIFO non-empty and host mode
rx_ready  in  1  host pop
rx  in  1  serial input, asynchronous
tx  out  1  serial output
tx_busy  out  1  frame in progress
tx_level  out  LVL_W  TX FIFO occupancy
rx_level  out  LVL_W  RX FIFO occupancy
err_parity  out  1  sticky parity error
err_frame  out  1  sticky framing error
err_overrun  out  1  sticky overrun
err_clear  in  1  clears all sticky flags

Behaviour:
- Clock, reset and outputs:
  - Clock is `clk`; reset is synchronous and active-high.
  - Reset values: tx=1, tx_busy=0, levels=0, rx_valid=0, all err flags=0, tick counter=0, both FSMs IDLE, rx synchroniser=2'b11.
  - tx_ready = ~tx_full & ~reset & ~cfg_echo.
- Reset asserted mid-frame aborts immediately; tx returns to 1 on the next edge.
- Tick generator:
  - The counter increments every clk.
  - s_tick pulses for 1 cycle when count==cfg_baud_div, and the counter then clears.
  - cfg_baud_div=0 gives s_tick every cycle.
  - There are 16 ticks per bit.
- Configuration (parity, stop, DATA_SIZE framing) is latched by each FSM when it leaves IDLE. Changes mid-frame do not affect the current frame.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if enabled) -> STOP -> IDLE.
  - In IDLE, on s_tick with the TX FIFO non-empty: pop the head into the shift register, drive tx=0, go to START.
  - Each state lasts 16 ticks. Data goes out LSB first.
  - Parity bit: even = XOR of data bits; odd = inverted XOR.
  - STOP lasts 16 ticks, or 32 if stop2. tx=1 throughout STOP.
  - tx is registered.
  - tx_busy=1 whenever the FSM is not in IDLE.
  - Back-to-back frames have no idle gap beyond the STOP period.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE. It operates on the rx signal after the 2-FF synchroniser.
  - In IDLE, a low rx on s_tick enters START.
  - At tick 7 of START, rx is re-sampled. If high, it is a glitch: return to IDLE with no flags set.
  - Data, parity and stop bits are each sampled mid-bit, 16 ticks apart.
  - Only the first stop bit is checked.
- End of an RX frame:
  - Stop sample = 0: set err_frame, discard the byte.
  - Parity mismatch: set err_parity, store the byte anyway.
  - RX FIFO full: set err_overrun, discard the byte, FIFO contents unchanged.
- Sticky flags:
  - err_clear clears the flags on the next edge.
  - A set event in the same cycle as err_clear wins (flag stays 1).
- FIFOs:
  - Circular buffers with LVL_W-bit levels.
  - Push is ignored when full.
  - A pop in the same cycle as a push at full does not free space for that push.
  - Push and pop together when neither empty nor full leave the level unchanged.
  - Pop is ignored when empty.
- Host mode (cfg_echo=0):
  - tx_valid&tx_ready pushes tx_data.
  - rx_valid=~rx_empty; rx_valid&rx_ready pops, and rx_data updates to the next head on the following cycle.
- Echo mode (cfg_echo=1):
  - tx_ready=0 and rx_valid=0; host strobes are ignored.
  - Each cycle with RX FIFO non-empty and TX FIFO not full moves one byte RX->TX (pop and push in the same cycle).
- Toggling cfg_echo does not flush either FIFO.

Test Plan:
1. div=0, 8N1, push 0xA5 while idle -> tx=0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 each 16 cycles, then 1 for 16 cycles; tx_busy high for 160 cycles; tx_level returns to 0.
2. Drive an even-parity 2-stop frame 0x3C into rx (div=3) -> rx_valid=1, rx_data=0x3C, rx_level=1, no errors. Repeat with the parity bit flipped -> byte stored, err_parity=1; err_clear -> 0.
3. FIFO_DEPTH=4, send 5 frames 0x01..0x05 without rx_ready -> rx_level=4, err_overrun=1; reads return 0x01..0x04.
4. Frame with stop bit 0 -> err_frame=1, rx_level unchanged. A 4-tick low glitch on rx -> no frame, no flags.
5. cfg_echo=1, inject 0x11,0x22,0x33 on rx -> the same bytes appear on tx in order; rx_valid and tx_ready stay 0.
6. Assert reset at bit 3 of a TX frame holding 2 queued bytes -> next cycle tx=1, tx_busy=0, tx_level=0; no further frames follow.
